// File: rtl/nibble_add_arbiter_pkg.sv
// Shared definitions for the nibble-serial add arbiter: state encoding,
// nibble size and the round-robin winner selection.
package nibble_add_arbiter_pkg;

    localparam int NIBBLE  = 4;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Scan requesters starting at last+1 (mod n) and return the first one
    // that is requesting; returns last when nobody requests.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req_vec,
                                           input logic [2:0]         last,
                                           input int                 n);
        logic [2:0] pick;
        logic [2:0] idx;
        logic       found;
        pick  = last;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            if (i <= n && !found) begin
                idx = 3'((int'(last) + i) % n);
                if (req_vec[idx]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/nibble_add_arbiter_fulladd4.sv
// Single 4-bit adder slice shared by all requesters; one nibble per cycle.
module fulladd4
    import nibble_add_arbiter_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              c_in,
    output logic              c_out,
    output logic [NIBBLE-1:0] sum
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE{1'b0}}, c_in};

endmodule

// File: rtl/nibble_add_arbiter.sv
// Round-robin arbiter granting one requester at a time access to a
// nibble-serial adder. The winner's operands are captured on the grant edge,
// added LSB nibble first over WIDTH/4 cycles, and the result is presented
// with a one-cycle done pulse.
module nibble_add_arbiter
    import nibble_add_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    a,
    input  logic [NREQ*WIDTH-1:0]    b,
    input  logic [NREQ-1:0]          cin,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NREQ)-1:0]  done_id,
    output logic [WIDTH-1:0]         sum,
    output logic                     cout
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int NNIB  = WIDTH / NIBBLE;
    localparam int CNT_W = $clog2(NNIB + 1);

    state_e              state_q;
    state_e              state_d;
    logic                take;
    logic                last_nib;
    logic [ID_W-1:0]     winner;
    logic [ID_W-1:0]     last_winner;
    logic [ID_W-1:0]     cur_id;
    logic [CNT_W-1:0]    cnt;
    logic [MAX_REQ-1:0]  req_ext;

    logic [WIDTH-1:0]    sel_a;
    logic [WIDTH-1:0]    sel_b;
    logic                sel_cin;

    // Operands shift right one nibble per RUN cycle; result fills from the top.
    logic [WIDTH-1:0]        a_sh;
    logic [WIDTH-1:0]        b_sh;
    logic                    carry;
    logic [WIDTH-1:0]        res;
    logic [WIDTH-1:0]        next_res;
    logic [WIDTH+NIBBLE-1:0] res_ext;
    logic [NIBBLE-1:0]       nib_sum;
    logic                    nib_cout;

    fulladd4 u_fulladd4 (
        .a     (a_sh[NIBBLE-1:0]),
        .b     (b_sh[NIBBLE-1:0]),
        .c_in  (carry),
        .c_out (nib_cout),
        .sum   (nib_sum)
    );

    assign res_ext  = {nib_sum, res};
    assign next_res = res_ext[WIDTH+NIBBLE-1:NIBBLE];
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

    // Next-state logic and round-robin winner selection.
    always_comb begin
        state_d  = state_q;
        take     = 1'b0;
        req_ext  = '0;
        req_ext[NREQ-1:0] = req;
        winner   = ID_W'(rr_pick(req_ext, 3'(last_winner), NREQ));
        last_nib = (cnt == '0);
        case (state_q)
            IDLE: begin
                if (|req) begin
                    take    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_nib) state_d = DONE;
            end
            DONE: begin
                if (|req) begin
                    take    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Select the winning requester's operands.
    always_comb begin
        sel_a   = a[WIDTH-1:0];
        sel_b   = b[WIDTH-1:0];
        sel_cin = cin[0];
        for (int i = 1; i < NREQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_a   = a[i*WIDTH +: WIDTH];
                sel_b   = b[i*WIDTH +: WIDTH];
                sel_cin = cin[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Grant pulse, round-robin pointer, nibble counter and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt         <= '0;
            last_winner <= ID_W'(NREQ - 1);
            cnt         <= '0;
            sum         <= '0;
            cout        <= 1'b0;
            done_id     <= '0;
        end else begin
            gnt <= '0;
            if (take) begin
                gnt         <= NREQ'(1) << winner;
                last_winner <= winner;
                cnt         <= CNT_W'(NNIB - 1);
            end else if (state_q == RUN) begin
                cnt <= cnt - CNT_W'(1);
                if (last_nib) begin
                    sum     <= next_res;
                    cout    <= nib_cout;
                    done_id <= cur_id;
                end
            end
        end
    end

    // Operand capture and nibble-serial accumulation.
    always_ff @(posedge clk) begin
        if (take) begin
            a_sh   <= sel_a;
            b_sh   <= sel_b;
            carry  <= sel_cin;
            cur_id <= winner;
        end else if (state_q == RUN) begin
            a_sh  <= a_sh >> NIBBLE;
            b_sh  <= b_sh >> NIBBLE;
            carry <= nib_cout;
            res   <= next_res;
        end
    end

endmodule

// File: doc/nibble_add_arbiter.md
NIBBLE_ADD_ARBITER -- requirements
Module: nibble_add_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the adder; SHALL be 2..8.
REQ-002 Parameter WIDTH, default 16: operand width; SHALL be a multiple of 4, minimum 4.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 req  input  NREQ  per-requester add request; bit i held high until gnt[i] is seen.
REQ-006 a  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 b  input  NREQ*WIDTH  operand B; same packing as a.
REQ-008 cin  input  NREQ  per-requester carry-in.
REQ-009 gnt  output  NREQ  one-hot, one-cycle pulse: operands of requester i captured.
REQ-010 busy  output  1  high while an operation is in RUN or DONE.
REQ-011 done  output  1  one-cycle pulse: sum, cout and done_id valid.
REQ-012 done_id  output  clog2(NREQ)  index of the requester whose result is on sum.
REQ-013 sum  output  WIDTH  result; held from the done pulse until the next done.
REQ-014 cout  output  1  carry-out of the full WIDTH add; held like sum.

Function
REQ-015 States SHALL be IDLE, RUN and DONE.
REQ-016 In IDLE or DONE with any req bit high, the arbiter SHALL pick the winner round-robin, capture a, b and cin for the winner, pulse gnt[winner] in the next cycle, and enter RUN.
REQ-017 Round-robin priority SHALL start at last_winner+1 modulo NREQ; last_winner updates only on a grant.
REQ-018 req SHALL be ignored while in RUN; gnt SHALL never be asserted in RUN except for the capture pulse.
REQ-019 RUN SHALL process one 4-bit nibble per cycle, LSB nibble first, through one shared 4-bit adder.
- Nibble 0 carry-in = captured cin.
- Nibble k carry-in = registered c_out of nibble k-1.
REQ-020 After WIDTH/4 RUN cycles the block SHALL enter DONE and assert done for exactly one cycle with the final sum, cout and done_id.
REQ-021 Latency SHALL be WIDTH/4+1 rising edges from the capture edge to the first cycle of done (5 for WIDTH=16).
REQ-022 Back-to-back operations: a grant taken in DONE SHALL give a throughput of one result per WIDTH/4+1 cycles.
REQ-023 From DONE with no req, the block SHALL return to IDLE.
REQ-024 sum and cout SHALL equal (A + B + cin) mod 2^(WIDTH+1), split as {cout, sum}.
REQ-025 busy SHALL be high exactly in RUN and DONE.

Reset
REQ-026 With rst_n low at an edge, the block SHALL enter IDLE and drive gnt=0, done=0, busy=0, sum=0, cout=0 and done_id=0.
REQ-027 Reset SHALL set last_winner to NREQ-1, so requester 0 wins first.
REQ-028 Reset during RUN or DONE SHALL abort the operation; no done SHALL be issued for it.

Structure
REQ-029 Package nibble_add_arbiter_pkg SHALL hold the state encoding, the NIBBLE=4 constant and the round-robin pick function.
REQ-030 The datapath SHALL instantiate exactly one fulladd4 (ports a, b, c_in, c_out, sum) as its only sub-module.

Verification
REQ-031 req0, a=0x1234, b=0x0FFF, cin=0 -> gnt[0] pulse; done 5 edges after capture; sum=0x2233, cout=0, done_id=0.
REQ-032 req1, a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, done_id=1 (full ripple through all nibbles).
REQ-033 All four req high together after reset -> grants in order 0,1,2,3; done every 5 cycles; each done_id matches its operands.
REQ-034 req0 and req2 held continuously -> grants alternate 0,2,0,2; req1 and req3 never granted.
REQ-035 rst_n low on the 2nd RUN cycle -> no done; all outputs 0 next cycle; next grant goes to req0.
REQ-036 WIDTH=4, NREQ=2, exhaustive sweep of all 512 (a,b,cin) combinations -> {cout,sum}=a+b+cin every time, 2-edge latency.
